window_3x3_gen: RTL and testbench



---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/line_shift_buf.sv | 50 +++++
 rtl/window_3x3_gen.sv | 155 +++++++++++++++
 tb/tb_window_3x3_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared constants for the pixel pipeline:
//     - default frame geometry and pixel width
//     - slice indices of a 3x3 window in a packed 9*DWIDTH bus
//       (TAP_ij is pixel (r-1+i, c-1+j) around centre (r,c))
//     - state encoding of the window generator
package pipeline_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int WIDTH_DEF  = 56;
    localparam int HEIGHT_DEF = 56;

    localparam int TAP_00 = 0;
    localparam int TAP_01 = 1;
    localparam int TAP_02 = 2;
    localparam int TAP_10 = 3;
    localparam int TAP_11 = 4;
    localparam int TAP_12 = 5;
    localparam int TAP_20 = 6;
    localparam int TAP_21 = 7;
    localparam int TAP_22 = 8;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

endpackage

// File: rtl/line_shift_buf.sv
// line_shift_buf
//   Enable-driven pixel shift register, DEPTH = 2*WIDTH+3 positions deep.
//   Position 0 is the newest pixel. The taps show the buffer as it looks once
//   din has been shifted in, so a window can be registered in the same cycle
//   its newest pixel arrives. Position 0 is therefore din itself and only
//   DEPTH-1 entries are actually stored.
//   Ports:
//     clk   clock
//     en    shift din in this cycle
//     din   incoming pixel
//     taps  positions 0, 1, 2, W, W+1, W+2, 2W, 2W+1, 2W+2 (taps[0..8])
module line_shift_buf #(
    parameter int DEPTH  = 115,
    parameter int DWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic [DWIDTH-1:0]      din,
    output logic [8:0][DWIDTH-1:0] taps
);

    localparam int LW = (DEPTH - 3) / 2;

    logic [DWIDTH-1:0] sr [DEPTH-1];

    // NOTE: pure data storage carries no reset; border masking downstream
    // hides whatever stale or power-up contents it holds.
    always_ff @(posedge clk) begin
        if (en) begin
            sr[0] <= din;
            for (int n = 1; n < DEPTH - 1; n++) begin
                sr[n] <= sr[n-1];
            end
        end
    end

    // Position p (p >= 1) after the shift is stored entry p-1 before it.
    always_comb begin
        taps[0] = din;
        taps[1] = sr[0];
        taps[2] = sr[1];
        taps[3] = sr[LW-1];
        taps[4] = sr[LW];
        taps[5] = sr[LW+1];
        taps[6] = sr[2*LW-1];
        taps[7] = sr[2*LW];
        taps[8] = sr[2*LW+1];
    end

endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen
//   Turns a raster-order pixel stream from a FIFO into one zero-padded 3x3
//   window per pixel. After the last pixel of a frame it shifts in zeros to
//   flush the final WIDTH+1 windows, then starts the next frame.
//   Ports:
//     clk, resetn  clock, asynchronous active-low reset
//     fifo_empty   input FIFO has no data
//     fifo_q       FIFO data, valid the cycle after fifo_rdreq
//     fifo_rdreq   FIFO read request
//     win_valid    win_data holds a window this cycle
//     win_data     9 pixels, slice [DWIDTH*(3*i+j) +: DWIDTH] = (r-1+i, c-1+j)
//     win_first    window centred at (0,0)
//     win_last     window centred at (HEIGHT-1, WIDTH-1)
module window_3x3_gen
    import pipeline_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  fifo_empty,
    input  logic [DWIDTH-1:0]     fifo_q,
    output logic                  fifo_rdreq,
    output logic                  win_valid,
    output logic [9*DWIDTH-1:0]   win_data,
    output logic                  win_first,
    output logic                  win_last
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] N_C       = CW'(N);
    localparam logic [CW-1:0] N_LAST    = CW'(N - 1);
    localparam logic [CW-1:0] FIRST_WIN = CW'(WIDTH + 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ROW_LAST  = CW'(HEIGHT - 1);

    logic [0:0]    state;
    logic          rd_d;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] px_cnt;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;

    logic                   shift_en;
    logic [DWIDTH-1:0]      shift_din;
    logic [8:0][DWIDTH-1:0] taps;
    logic                   emit;
    logic                   at_last;
    logic                   z_top, z_bot, z_left, z_right;
    logic [9*DWIDTH-1:0]    win_next;

    // Gated by resetn so the request drops the instant reset asserts.
    assign fifo_rdreq = resetn && (state == RUN) && !fifo_empty && (rd_cnt < N_C);

    // FLUSH pushes zeros so the bottom-right windows complete without input.
    assign shift_en  = rd_d || (state == FLUSH);
    assign shift_din = (state == FLUSH) ? '0 : fifo_q;

    line_shift_buf #(
        .DEPTH  (2 * WIDTH + 3),
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk  (clk),
        .en   (shift_en),
        .din  (shift_din),
        .taps (taps)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        emit     = 1'b0;
        win_next = '0;
        if (state == FLUSH) begin
            emit = 1'b1;
        end else if (rd_d && (px_cnt >= FIRST_WIN)) begin
            emit = 1'b1;
        end

        at_last = (out_row == ROW_LAST) && (out_col == COL_LAST);
        z_top   = (out_row == '0);
        z_bot   = (out_row == ROW_LAST);
        z_left  = (out_col == '0);
        z_right = (out_col == COL_LAST);

        // Window pixel (i,j) sits at buffer position (2-i)*WIDTH + (2-j),
        // i.e. taps[8-(3i+j)]. Masking also hides row wrap and the tail of
        // the previous frame.
        win_next[DWIDTH*TAP_00 +: DWIDTH] = (z_top || z_left)  ? '0 : taps[8];
        win_next[DWIDTH*TAP_01 +: DWIDTH] = z_top              ? '0 : taps[7];
        win_next[DWIDTH*TAP_02 +: DWIDTH] = (z_top || z_right) ? '0 : taps[6];
        win_next[DWIDTH*TAP_10 +: DWIDTH] = z_left             ? '0 : taps[5];
        win_next[DWIDTH*TAP_11 +: DWIDTH] = taps[4];
        win_next[DWIDTH*TAP_12 +: DWIDTH] = z_right            ? '0 : taps[3];
        win_next[DWIDTH*TAP_20 +: DWIDTH] = (z_bot || z_left)  ? '0 : taps[2];
        win_next[DWIDTH*TAP_21 +: DWIDTH] = z_bot              ? '0 : taps[1];
        win_next[DWIDTH*TAP_22 +: DWIDTH] = (z_bot || z_right) ? '0 : taps[0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= RUN;
            rd_d      <= 1'b0;
            rd_cnt    <= '0;
            px_cnt    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            win_valid <= 1'b0;
            win_first <= 1'b0;
            win_last  <= 1'b0;
            win_data  <= '0;
        end else begin
            rd_d      <= fifo_rdreq;
            win_valid <= emit;
            win_first <= emit && z_top && z_left;
            win_last  <= emit && at_last;
            if (emit) begin
                win_data <= win_next;
            end

            if (fifo_rdreq) begin
                rd_cnt <= rd_cnt + 1'b1;
            end

            if (rd_d && (state == RUN)) begin
                px_cnt <= px_cnt + 1'b1;
                if (px_cnt == N_LAST) begin
                    state <= FLUSH;
                end
            end

            if (emit) begin
                if (at_last) begin
                    out_row <= '0;
                    out_col <= '0;
                    if (state == FLUSH) begin
                        rd_cnt <= '0;
                        px_cnt <= '0;
                        state  <= RUN;
                    end
                end else if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen
//   Directed bench for window_3x3_gen on a 4x4 frame: basic frame, latency
//   and flush timing, random FIFO-empty stalls, back-to-back frames and a
//   mid-frame reset. Expected windows come from a coordinate-based model
//   plus hand-written vectors.
module tb_window_3x3_gen;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NP = W * H;
    localparam int XW = 9 * DW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_q = '0;
    logic          fifo_rdreq;
    logic          win_valid;
    logic [XW-1:0] win_data;
    logic          win_first;
    logic          win_last;

    window_3x3_gen #(.DWIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rdreq (fifo_rdreq),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .win_first  (win_first),
        .win_last   (win_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // FIFO model: the initial block only appends words and raises stalls,
    // this process only consumes.
    logic [DW-1:0] src [0:255];
    int            src_len    = 0;
    int            rd_ptr     = 0;
    bit            stall      = 1'b0;
    bit            fifo_flush = 1'b0;

    always_comb fifo_empty = (rd_ptr >= src_len) || stall;

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= src_len;
        end else if (fifo_rdreq && (rd_ptr < src_len)) begin
            fifo_q <= src[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Monitor, sampled on the falling edge.
    int            cyc    = 0;
    int            rd_tot = 0;
    int            win_tot = 0;
    int            bad_rd = 0;
    int            rd_cyc   [0:255];
    logic [XW-1:0] cap_data [0:255];
    logic          cap_first[0:255];
    logic          cap_last [0:255];
    logic          cap_rd   [0:255];
    int            cap_cyc  [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_rdreq) begin
            if (rd_tot < 256) rd_cyc[rd_tot] <= cyc;
            rd_tot <= rd_tot + 1;
            if (fifo_empty) bad_rd <= bad_rd + 1;
        end
        if (win_valid && (win_tot < 256)) begin
            cap_data[win_tot]  <= win_data;
            cap_first[win_tot] <= win_first;
            cap_last[win_tot]  <= win_last;
            cap_rd[win_tot]    <= fifo_rdreq;
            cap_cyc[win_tot]   <= cyc;
            win_tot            <= win_tot + 1;
        end
    end

    task automatic check(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [XW-1:0] pack9(input int a [9]);
        logic [XW-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[DW*k +: DW] = DW'(a[k]);
        return w;
    endfunction

    // Pixel (rr,cc) of a frame is base + rr*W + cc + 1; outside the frame 0.
    function automatic logic [XW-1:0] model_win(input int r, input int c, input int base);
        logic [XW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int rr;
                int cc;
                rr = r - 1 + i;
                cc = c - 1 + j;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    w[DW*(3*i+j) +: DW] = DW'(base + rr*W + cc + 1);
            end
        end
        return w;
    endfunction

    task automatic push_frame(input int base);
        for (int i = 0; i < NP; i++) src[src_len + i] = DW'(base + i + 1);
        src_len = src_len + NP;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_win(input int target, input int budget, input bit rnd);
        int n;
        n = 0;
        while (win_tot < target && n < budget) begin
            step();
            if (rnd) stall = 1'($urandom_range(0, 1));
            n++;
        end
        stall = 1'b0;
        if (win_tot < target) check("timeout", XW'(win_tot), XW'(target));
        repeat (6) step();
    endtask

    task automatic check_frame(input string tag, input int ws, input int base);
        for (int n = 0; n < NP; n++) begin
            check($sformatf("%s_win%0d", tag, n), cap_data[ws+n], model_win(n / W, n % W, base));
            check($sformatf("%s_flags%0d", tag, n), XW'({cap_first[ws+n], cap_last[ws+n]}),
                  XW'({n == 0, n == NP - 1}));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rdreq"}, XW'(fifo_rdreq), '0);
        check({tag, "_valid"}, XW'(win_valid), '0);
        check({tag, "_first"}, XW'(win_first), '0);
        check({tag, "_last"},  XW'(win_last),  '0);
        check({tag, "_data"},  win_data,       '0);
    endtask

    int ws;
    int rs;
    int bad0;

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        step();
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_rdreq_empty", XW'(fifo_rdreq), '0);

        // Basic frame, FIFO never empty.
        ws = win_tot;
        rs = rd_tot;
        step();
        push_frame(0);
        wait_win(ws + NP, 200, 1'b0);
        check("basic_count", XW'(win_tot - ws), XW'(NP));
        check("basic_reads", XW'(rd_tot - rs), XW'(NP));
        check("basic_first", cap_data[ws],      pack9('{0, 0, 0, 0, 1, 2, 0, 5, 6}));
        check("basic_c11",   cap_data[ws + 5],  pack9('{1, 2, 3, 5, 6, 7, 9, 10, 11}));
        check("basic_last",  cap_data[ws + 15], pack9('{11, 12, 0, 15, 16, 0, 0, 0, 0}));
        check_frame("basic", ws, 0);

        // Latency: read of pixel 5 -> first window two cycles later.
        check("latency", XW'(cap_cyc[ws] - rd_cyc[rs + 5]), XW'(2));
        check("latency_centre", XW'(cap_data[ws][DW*4 +: DW]), XW'(1));
        // Flush: last RUN window and the 5 flush windows are back to back.
        check("flush_span", XW'(cap_cyc[ws + 15] - cap_cyc[ws + 10]), XW'(5));
        for (int n = 11; n < NP; n++)
            check($sformatf("flush_rdreq%0d", n), XW'(cap_rd[ws + n]), '0);

        // Random empty stalls.
        ws   = win_tot;
        rs   = rd_tot;
        bad0 = bad_rd;
        push_frame(0);
        wait_win(ws + NP, 2000, 1'b1);
        check("stall_count", XW'(win_tot - ws), XW'(NP));
        check("stall_reads", XW'(rd_tot - rs), XW'(NP));
        check("stall_rd_while_empty", XW'(bad_rd - bad0), '0);
        check_frame("stall", ws, 0);

        // Back-to-back frames.
        ws = win_tot;
        rs = rd_tot;
        push_frame(0);
        push_frame(100);
        wait_win(ws + 2 * NP, 400, 1'b0);
        check("b2b_count", XW'(win_tot - ws), XW'(2 * NP));
        check("b2b_reads", XW'(rd_tot - rs), XW'(2 * NP));
        check("b2b_f2_first", cap_data[ws + NP], pack9('{0, 0, 0, 0, 101, 102, 0, 105, 106}));
        check_frame("b2b_f1", ws, 0);
        check_frame("b2b_f2", ws + NP, 100);

        // Reset after 7 pixels accepted.
        rs = rd_tot;
        push_frame(0);
        begin
            int n;
            n = 0;
            while (rd_tot < rs + 7 && n < 200) begin
                step();
                n++;
            end
            check("mid_reads_reached", XW'(rd_tot >= rs + 7), XW'(1));
        end
        step();
        resetn     = 1'b0;
        fifo_flush = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        step();
        fifo_flush = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset_hold");
        step();
        resetn = 1'b1;
        ws = win_tot;
        rs = rd_tot;
        push_frame(0);
        wait_win(ws + NP, 200, 1'b0);
        check("after_reset_count", XW'(win_tot - ws), XW'(NP));
        check("after_reset_reads", XW'(rd_tot - rs), XW'(NP));
        check("after_reset_first", cap_data[ws], pack9('{0, 0, 0, 0, 1, 2, 0, 5, 6}));
        check_frame("after_reset", ws, 0);
        check("total_rd_while_empty", XW'(bad_rd), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
